// File: rtl/tdm_pkg.sv
// Shared constants for the 1:4 TDM demultiplexer.
//   SLOT_CH0..SLOT_CH3 : slot indices in transmit order
//   N_CH               : number of channels per frame
//   tdm_state_e        : frame-alignment FSM encoding (HUNT / LOCK)
package tdm_pkg;

    localparam int N_CH = 4;

    localparam logic [1:0] SLOT_CH0 = 2'd0;
    localparam logic [1:0] SLOT_CH1 = 2'd1;
    localparam logic [1:0] SLOT_CH2 = 2'd2;
    localparam logic [1:0] SLOT_CH3 = 2'd3;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// Bus bundle for the 1:4 TDM demultiplexer.
//   en, sync, din : multiplexed stream in (driven by the master)
//   out           : last complete frame, ch k at out[k*DW +: DW]
//   frame_vld     : one-cycle pulse when out is updated
//   slot          : slot index expected at the next en
//   locked        : frame alignment acquired
//   sync_err      : one-cycle pulse on a misaligned sync while locked
// master = stream source / frame consumer, slave = the demultiplexer.
interface tdm_demux_1to4_if
    import tdm_pkg::*;
#(
    parameter int DW = 1
);
    logic               en;
    logic               sync;
    logic [DW-1:0]      din;
    logic [N_CH*DW-1:0] out;
    logic               frame_vld;
    logic [1:0]         slot;
    logic               locked;
    logic               sync_err;

    modport master (
        output en, sync, din,
        input  out, frame_vld, slot, locked, sync_err
    );

    modport slave (
        input  en, sync, din,
        output out, frame_vld, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_cnt.sv
// 2-bit slot counter for the TDM demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to slot 0
//   load1      : force the count to slot 1 (slot 0 was just taken with a sync)
//   inc        : advance one slot, wrapping 3 -> 0
//   cnt        : current count (registered)
//   wrap       : count is at the last slot of the frame
// Priority: clear > load1 > inc.
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load1,
    input  logic       inc,
    output logic [1:0] cnt,
    output logic       wrap
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = SLOT_CH0;
        end else if (load1) begin
            cnt_d = SLOT_CH1;
        end else if (inc) begin
            cnt_d = (cnt_q == SLOT_CH3) ? SLOT_CH0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= SLOT_CH0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == SLOT_CH3);

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer (receive side of the 4:1 channel mux).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of tdm_demux_1to4_if (stream in, frame out,
//                slot index, lock status and error/valid pulses)
// A sync strobed with en marks slot 0. Slots 0..2 are parked in shadow
// registers; the slot-3 sample goes straight into the output register
// together with the shadows, so a frame appears one clock after its last
// slot. A sync at any other slot while locked drops the partial frame and
// restarts at slot 1 with the new slot-0 sample.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int DW = 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    tdm_demux_1to4_if.slave         bus
);

    tdm_state_e                     state_q, state_d;
    logic [N_CH-2:0][DW-1:0]        shadow_q, shadow_d;
    logic [N_CH*DW-1:0]             out_q, out_d;
    logic                           frame_vld_q, frame_vld_d;
    logic                           sync_err_q, sync_err_d;

    logic [1:0] slot;
    logic       slot_wrap;
    logic       is_lock;
    logic       take_sync;   // en & sync: (re)start a frame at slot 0
    logic       take_data;   // en & !sync while locked: ordinary slot
    logic [1:0] wr_slot;     // slot the current sample belongs to

    assign is_lock   = (state_q == ST_LOCK);
    assign take_sync = bus.en && bus.sync;
    assign take_data = bus.en && !bus.sync && is_lock;
    assign wr_slot   = take_sync ? SLOT_CH0 : slot;

    tdm_slot_cnt u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.en && !bus.sync && !is_lock),
        .load1 (take_sync),
        .inc   (take_data),
        .cnt   (slot),
        .wrap  (slot_wrap)
    );

    // One shadow register per slot 0..N_CH-2; the last slot never needs one.
    generate
        for (genvar gi = 0; gi < N_CH - 1; gi++) begin : g_shadow
            assign shadow_d[gi] = ((take_sync || take_data) && (wr_slot == 2'(gi)))
                                  ? bus.din : shadow_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        frame_vld_d = 1'b0;
        sync_err_d  = 1'b0;

        if (take_sync) begin
            state_d    = ST_LOCK;
            // Sync at slot 0 while locked is just an optional realignment mark.
            sync_err_d = is_lock && (slot != SLOT_CH0);
        end else if (take_data && slot_wrap) begin
            out_d       = {bus.din, shadow_q};
            frame_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            shadow_q    <= '0;
            out_q       <= '0;
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            frame_vld_q <= frame_vld_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.frame_vld = frame_vld_q;
    assign bus.slot      = slot;
    assign bus.locked    = is_lock;
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4 with DW=1.
// A queue-based frame model predicts every output; a compare process checks
// the DUT against it on each falling edge, and directed scenarios add literal
// checks that pin the model to hand-computed values.
module tb_tdm_demux_1to4;

    localparam int DW = 1;

    logic clk = 1'b0;
    logic rst_n;

    tdm_demux_1to4_if #(.DW(DW)) bus ();

    tdm_demux_1to4 #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    logic       q[$];        // slots collected for the current frame
    logic       m_locked;
    logic [3:0] m_out;
    logic       m_fv;
    logic       m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_locked = 1'b0;
            m_out    = 4'b0;
            m_fv     = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_fv  = 1'b0;
            m_err = 1'b0;
            if (bus.en) begin
                if (bus.sync) begin
                    if (m_locked && q.size() != 0) m_err = 1'b1;
                    q.delete();
                    q.push_back(bus.din);
                    m_locked = 1'b1;
                end else if (m_locked) begin
                    q.push_back(bus.din);
                    if (q.size() == 4) begin
                        m_out = {q[3], q[2], q[1], q[0]};
                        m_fv  = 1'b1;
                        q.delete();
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [1:0] exp_slot;
        exp_slot = 2'(q.size());
        vectors++;
        if (bus.out !== m_out || bus.frame_vld !== m_fv || bus.slot !== exp_slot ||
            bus.locked !== m_locked || bus.sync_err !== m_err) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got out=%b vld=%b slot=%0d lock=%b err=%b, want out=%b vld=%b slot=%0d lock=%b err=%b",
                     $time, bus.out, bus.frame_vld, bus.slot, bus.locked, bus.sync_err,
                     m_out, m_fv, exp_slot, m_locked, m_err);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the falling edge.
    task automatic tick(input logic e, input logic s, input logic d);
        @(negedge clk);
        #1;
        bus.en   = e;
        bus.sync = s;
        bus.din  = d;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = 1'b0;
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = 1'b0;

        // 1: reset held 3 clocks
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        check("rst_out",    32'(bus.out),       32'h0);
        check("rst_slot",   32'(bus.slot),      32'h0);
        check("rst_locked", 32'(bus.locked),    32'h0);
        check("rst_vld",    32'(bus.frame_vld), 32'h0);
        check("rst_err",    32'(bus.sync_err),  32'h0);
        release_reset();

        // 2: hunting, data without sync is ignored
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'(i));
        tick(1'b0, 1'b0, 1'b0);
        check("hunt_slot",   32'(bus.slot),   32'h0);
        check("hunt_locked", 32'(bus.locked), 32'h0);

        // 3: back-to-back frame 1,0,1,1
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        check("f3_locked", 32'(bus.locked), 32'h1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("f3_out", 32'(bus.out),       32'hD);
        check("f3_vld", 32'(bus.frame_vld), 32'h1);
        tick(1'b0, 1'b0, 1'b0);
        check("f3_vld_once", 32'(bus.frame_vld), 32'h0);

        // frame 0,1,0,0 so the gapped frame visibly changes out
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("f_mid_out", 32'(bus.out), 32'h2);

        // 4: gapped en, din/sync toggling while en=0
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("f4_hold_out", 32'(bus.out),       32'h2);
        check("f4_hold_vld", 32'(bus.frame_vld), 32'h0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check("f4_out", 32'(bus.out),       32'hD);
        check("f4_vld", 32'(bus.frame_vld), 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        check("f4_vld_once", 32'(bus.frame_vld), 32'h0);

        // 5: misaligned sync after two slots
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("f5_err", 32'(bus.sync_err),  32'h1);
        check("f5_vld", 32'(bus.frame_vld), 32'h0);
        check("f5_out_kept", 32'(bus.out),  32'hD);
        tick(1'b1, 1'b0, 1'b1);
        check("f5_err_once", 32'(bus.sync_err), 32'h0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("f5_out", 32'(bus.out),       32'hE);
        check("f5_vld2", 32'(bus.frame_vld), 32'h1);
        check("f5_err2", 32'(bus.sync_err),  32'h0);

        // 6: reset in the middle of a frame
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        do_reset(2);
        check("f6_rst_out",    32'(bus.out),    32'h0);
        check("f6_rst_locked", 32'(bus.locked), 32'h0);
        check("f6_rst_slot",   32'(bus.slot),   32'h0);
        release_reset();
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("f6_out", 32'(bus.out),       32'h6);
        check("f6_vld", 32'(bus.frame_vld), 32'h1);

        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
